// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - fragment FIFO plus read-modify-write engine for a packed 1-bpp framebuffer
// Optional feature macro: WORD_CACHE_EN (1-entry word cache that skips the read on a tag hit)

module fb_pixel_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_PIXELS  = 307200,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic [18:0]   pix_addr,
    input  logic          pix_color,
    output logic          pix_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [14:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          drop_pulse,
    output logic          busy
);

    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [19:0]     FB_LIM   = 20'(FB_PIXELS);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [19:0]     fifo_mem_q [FIFO_DEPTH];
    logic            work_valid_q, work_valid_d;
    logic [18:0]     work_addr_q, work_addr_d;
    logic            work_color_q, work_color_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [14:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            drop_q, drop_d;

    logic            push, pop, out_of_range, issue, cache_hit;
    logic [19:0]     head;
    logic [DW-1:0]   hit_data;

    function automatic logic [DW-1:0] merge_bit(input logic [DW-1:0] w, input logic [3:0] idx,
                                                input logic c);
        logic [DW-1:0] r;
        r      = w;
        r[idx] = c;
        return r;
    endfunction

    assign pix_ready    = (count_q != FULL_CNT);
    assign push         = pix_valid & pix_ready;
    assign pop          = (state_q == ST_IDLE) && !work_valid_q && (count_q != '0);
    assign head         = fifo_mem_q[rd_ptr_q];
    assign out_of_range = ({1'b0, work_addr_q} >= FB_LIM);
    assign issue        = (state_q == ST_IDLE) && work_valid_q && !out_of_range;

`ifdef WORD_CACHE_EN
    logic            cache_valid_q, cache_valid_d;
    logic [14:0]     cache_tag_q, cache_tag_d;
    logic [DW-1:0]   cache_data_q, cache_data_d;

    assign cache_hit = cache_valid_q && (cache_tag_q == work_addr_q[18:4]);
    assign hit_data  = cache_data_q;

    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if (state_q == ST_WR && mem_ack) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = mem_addr_q;
            cache_data_d  = mem_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    // FIFO storage needs no reset; only pointers and count define its contents
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {pix_color, pix_addr};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            work_valid_q <= 1'b0;
            work_addr_q  <= '0;
            work_color_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            work_valid_q <= work_valid_d;
            work_addr_q  <= work_addr_d;
            work_color_q <= work_color_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue)   state_d = cache_hit ? ST_WR : ST_RD;
            ST_RD:   if (mem_ack) state_d = ST_WR;
            ST_WR:   if (mem_ack) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q;
        work_valid_d = work_valid_q;
        work_addr_d  = work_addr_q;
        work_color_d = work_color_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        drop_d       = 1'b0;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A fragment sits one cycle in the working registers before its range check issues
        if (pop) begin
            work_valid_d = 1'b1;
            work_addr_d  = head[18:0];
            work_color_d = head[19];
        end else if (state_q == ST_IDLE && work_valid_q) begin
            work_valid_d = 1'b0;
            drop_d       = out_of_range;
        end

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = work_addr_q[18:4];
                    mem_we_d   = cache_hit;
                    if (cache_hit) mem_wdata_d = merge_bit(hit_data, work_addr_q[3:0], work_color_q);
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_bit(mem_rdata, work_addr_q[3:0], work_color_q);
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign drop_pulse = drop_q;
    assign busy       = (count_q != '0) || (state_q != ST_IDLE) || work_valid_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - table-driven and scoreboard bench for fb_pixel_writer

module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic [18:0] pix_addr = '0;
    logic        pix_color = 1'b0;
    logic        pix_ready;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        drop_pulse, busy;

    fb_pixel_writer dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_color(pix_color),
        .pix_ready(pix_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .drop_pulse(drop_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [15:0] data;
    } txn_t;

    typedef struct {
        logic [18:0] addr;
        logic        color;
        logic [15:0] rdata;
        logic [14:0] exp_word;
        logic [15:0] exp_wdata;
    } vec_t;

    txn_t        sb[$];
    vec_t        vecs[7];
    logic [15:0] tb_mem  [0:32767];
    logic [15:0] ref_mem [0:32767];

    int          ncmp = 0, nfail = 0;
    int          ack_delay = 1, wait_cnt = 0;
    bit          stall = 0;
    int          nreads = 0, nwrites = 0, drop_seen = 0, exp_drops = 0;
    logic [14:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    bit          m_cache_valid = 0;
    logic [14:0] m_cache_tag = '0;
    logic [15:0] m_cache_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [18:0] a, input logic c);
        logic [14:0] w;
        logic [15:0] base, nw;
        bit          hit;
        if (a >= 19'd307200) begin
            exp_drops++;
        end else begin
            w   = a[18:4];
            hit = 0;
`ifdef WORD_CACHE_EN
            hit = m_cache_valid && (m_cache_tag == w);
`endif
            base        = hit ? m_cache_data : ref_mem[w];
            nw          = base;
            nw[a[3:0]]  = c;
            if (!hit) sb.push_back('{1'b0, w, 16'h0000});
            sb.push_back('{1'b1, w, nw});
            ref_mem[w]    = nw;
            m_cache_valid = 1;
            m_cache_tag   = w;
            m_cache_data  = nw;
        end
    endtask

    task automatic service();
        txn_t e;
        if (sb.size() == 0) begin
            check("unexpected_txn", {mem_we, mem_addr}, 64'h0);
            nfail += (mem_we == 1'b0 && mem_addr == '0) ? 1 : 0;
        end else begin
            e = sb.pop_front();
            check("txn", {mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0)},
                  {e.we, e.addr, (e.we ? e.data : 16'h0)});
        end
        if (mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
            last_wr_addr     = mem_addr;
            last_wr_data     = mem_wdata;
            nwrites++;
        end else begin
            mem_rdata = tb_mem[mem_addr];
            nreads++;
        end
    endtask

    // Memory responder: one-cycle ack after ack_delay waiting cycles
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (rst && mem_req && !stall) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    service();
                    mem_ack = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (drop_pulse) drop_seen++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic preload(input logic [14:0] w, input logic [15:0] d);
        tb_mem[w]  = d;
        ref_mem[w] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b0;
        sb.delete();
        m_cache_valid = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {mem_req, mem_we, mem_addr, mem_wdata, drop_pulse, busy, pix_ready},
              {1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b1});
        ref_mem = tb_mem;
        rst = 1'b1;
    endtask

    task automatic push(input logic [18:0] a, input logic c);
        int n = 0;
        pix_valid = 1'b1;
        pix_addr  = a;
        pix_color = c;
        while (!pix_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            check("push_timeout", {63'h0, pix_ready}, 64'h1);
        end else begin
            @(posedge clk);
            model_accept(a, c);
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || mem_req) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {62'h0, busy, mem_req}, 64'h0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int r0, w0, d0, n;
        for (int i = 0; i < 32768; i++) tb_mem[i] = 16'h0000;
        ref_mem = tb_mem;

        vecs[0] = '{19'h00021, 1'b1, 16'h0000, 15'h0002, 16'h0002};
        vecs[1] = '{19'h0002F, 1'b0, 16'hFFFF, 15'h0002, 16'h7FFF};
        vecs[2] = '{19'h00000, 1'b1, 16'h0000, 15'h0000, 16'h0001};
        vecs[3] = '{19'h4AFFF, 1'b1, 16'h0000, 15'h4AFF, 16'h8000};
        vecs[4] = '{19'h12345, 1'b0, 16'h0020, 15'h1234, 16'h0000};
        vecs[5] = '{19'h00107, 1'b1, 16'hA5A5, 15'h0010, 16'hA5A5};
        vecs[6] = '{19'h00108, 1'b1, 16'h0000, 15'h0010, 16'h0100};

        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            preload(vecs[v].addr[18:4], vecs[v].rdata);
            r0 = nreads;
            push(vecs[v].addr, vecs[v].color);
            wait_idle();
            check($sformatf("vec%0d_wr_addr", v), last_wr_addr, vecs[v].exp_word);
            check($sformatf("vec%0d_wr_data", v), last_wr_data, vecs[v].exp_wdata);
            check($sformatf("vec%0d_reads", v), nreads - r0, 1);
        end

        // Latency: accept at edge N, pop at N+1, mem_req visible after N+2
        do_reset();
        pix_valid = 1'b1; pix_addr = 19'h00050; pix_color = 1'b1;
        @(posedge clk);
        model_accept(19'h00050, 1'b1);
        #1 pix_valid = 1'b0;
        @(posedge clk); #1;
        check("lat_n1_req", {62'h0, mem_req, busy}, 64'h1);
        @(posedge clk); #1;
        check("lat_n2_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 15'h0005});
        wait_idle();

        // Stall: 9 fragments fill working regs plus the 8-entry FIFO
        do_reset();
        stall = 1;
        w0 = nwrites;
        for (int i = 0; i < 9; i++) push(19'((i + 32) * 16 + i), i[0]);
        check("full_after_9", {63'h0, pix_ready}, 64'h0);
        pix_valid = 1'b1; pix_addr = 19'h07777; pix_color = 1'b1;
        repeat (5) @(negedge clk);
        check("refused_when_full", {63'h0, pix_ready}, 64'h0);
        check("stalled_read", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 15'd32});
        pix_valid = 1'b0;
        stall = 0;
        wait_idle();
        check("stall_writes", nwrites - w0, 9);

        // Out-of-range drops
        do_reset();
        d0 = drop_seen; r0 = nreads; w0 = nwrites; exp_drops = 0;
        push(19'd307200, 1'b1);
        push(19'h7FFFF, 1'b0);
        wait_idle();
        check("drop_pulses", drop_seen - d0, 2);
        check("drop_model", exp_drops, 2);
        check("drop_no_mem", (nreads - r0) + (nwrites - w0), 0);
        push(19'h00333, 1'b1);
        wait_idle();
        check("after_drop_write", {last_wr_addr, last_wr_data}, {15'h0033, 16'h0008});

        // Two pixels in the same word
        do_reset();
        preload(15'h0010, 16'h0000);
        r0 = nreads;
        push(19'h00100, 1'b1);
        push(19'h00101, 1'b1);
        wait_idle();
        check("pair_wdata", last_wr_data, 16'h0003);
`ifdef WORD_CACHE_EN
        check("pair_reads", nreads - r0, 1);
`else
        check("pair_reads", nreads - r0, 2);
`endif

        // Async reset during a stalled read
        do_reset();
        push(19'h00200, 1'b1);
        wait_idle();
        stall = 1;
        push(19'h00300, 1'b1);
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_reached", {mem_req, mem_we}, {1'b1, 1'b0});
        #2 rst = 1'b0;
        #1 check("async_req_drop", {63'h0, mem_req}, 64'h0);
        sb.delete();
        m_cache_valid = 0;
        ref_mem = tb_mem;
        stall = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {62'h0, busy, pix_ready}, 64'h1);
        r0 = nreads;
        push(19'h00201, 1'b1);
        wait_idle();
        check("post_reset_reads", nreads - r0, 1);
        check("post_reset_wdata", last_wr_data, 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
